serial_subtractor_ctrl: RTL
===========================

# serial_subtractor_ctrl

Bit-serial N-bit subtractor controller that sequences a single one-bit full-subtractor cell over WIDTH cycles to compute a − b − bin. It sits alongside the combinational adder/subtractor blocks as the area-minimal alternative: one subtract cell, one borrow flop, shift registers and a small FSM. It uses a start/busy/done handshake with a registered result.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result registers update.
- diff  output  WIDTH  registered difference, (a − b − bin) mod 2^WIDTH.
- bout  output  1  registered borrow-out; 1 iff a < b + bin (unsigned).
- ovf  output  1  registered signed overflow; see Configuration.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE → SHIFT when start=1:
  - load a_sr←a and b_sr←b.
  - load brw←bin, cnt←0 and res_sr←0.
- SHIFT, every cycle:
  - the cell computes d = a_sr[0]^b_sr[0]^brw and nb = (~a_sr[0]&b_sr[0]) | (~a_sr[0]&brw) | (b_sr[0]&brw).
  - a_sr and b_sr shift right; res_sr shifts right with d entering the MSB.
  - brw←nb and cnt←cnt+1.
  - when cnt==WIDTH−1, go to DONE.
- DONE, for one cycle:
  - diff←final res_sr and bout←brw.
  - ovf is updated (if enabled).
  - done=1, then return to IDLE.
- start is ignored in SHIFT and DONE. No queuing and no error flag.
- Changes on a/b/bin after acceptance have no effect.
- diff, bout and ovf hold their last value through the next operation until the next DONE.
- cnt is $clog2(WIDTH) bits wide and never wraps inside an operation.
- Reset:
  - state→IDLE; busy, done, diff, bout and ovf go to 0; internal registers are cleared.
  - Reset mid-SHIFT aborts the operation: no done pulse, outputs are 0.
  - Reset asserted together with start: reset wins.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycles 1..WIDTH: busy=1 (SHIFT).
- Cycle WIDTH+1: done=1, busy=0, new diff/bout/ovf visible.
- Latency from start to done is WIDTH+1 cycles.
- A new start is accepted at the earliest in cycle WIDTH+2 (IDLE), so throughput is one operation per WIDTH+2 cycles.
- A start held high continuously re-triggers on every IDLE cycle.

## Configuration
- Macro SERSUB_OVF_EN.
- With the macro defined:
  - ovf ← (a[MSB]≠b[MSB]) & (diff[MSB]≠a[MSB]), evaluated on the captured operands.
  - ovf is registered in DONE.
  - The MSBs of a and b are kept in two extra flops captured at start.
- Without the macro:
  - The ovf port remains and is tied to constant 0.
  - No extra flops are present.

## Structure
- Package sersub_pkg holds:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the default WIDTH constant;
  - a function returning the counter width.
- Sub-module fs_cell is the combinational one-bit full subtractor (inputs a, b, c; outputs diff, borrow), instantiated once.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, bin=0, start pulse → busy for cycles 1–8, done at cycle 9, diff=0x37, bout=0, ovf=0.
- a=0x10, b=0x20, bin=1 → diff=0xEF, bout=1; with SERSUB_OVF_EN, ovf=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1 with SERSUB_OVF_EN and 0 without.
- start pulsed at cycles 3 and 9 of a running operation, with changed a/b → ignored; the first result is unaffected and no second done pulse follows.
- rst asserted at cycle 4 of SHIFT → next cycle IDLE, busy=0, diff=0, bout=0, and no done pulse; a fresh start then completes normally.
- Exhaustive check for WIDTH=4 over all a, b and bin → diff and bout match a−b−bin for all 512 cases; done occurs exactly WIDTH+1 cycles after each start.

Source files
------------

// File: rtl/sersub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor controller.
package sersub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SERSUB_WIDTH = 8;

    // Counter must index 0..w-1; a 1-bit floor keeps degenerate widths legal.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: computes a - b - c, producing difference and borrow.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ c;
    assign borrow = (~a & b) | (~a & c) | (b & c);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin) built around one fs_cell.
// Optional signed-overflow flag is enabled by defining SERSUB_OVF_EN.
module serial_subtractor_ctrl
    import sersub_pkg::*;
#(
    parameter int WIDTH = SERSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt, diff_r;
    logic [CW-1:0]    cnt;
    logic             brw, bout_r;
    logic             d, nb;
    logic             last_bit;

    fs_cell u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .c      (brw),
        .diff   (d),
        .borrow (nb)
    );

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign res_nxt  = {d, {(WIDTH-1){1'b0}}} | (res_sr >> 1);

    // Handshake: start is accepted only in IDLE; busy marks the WIDTH SHIFT
    // cycles; done pulses for exactly one cycle while diff/bout/ovf are new.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            diff_r <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            bout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr   <= a;
                    b_sr   <= b;
                    brw    <= bin;
                    cnt    <= '0;
                    res_sr <= '0;
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    brw    <= nb;
                    if (cnt != LAST) cnt <= cnt + CW'(1);
                    // Publish on the last shift so the result is visible during DONE.
                    if (last_bit) begin
                        diff_r <= res_nxt;
                        bout_r <= nb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_r;
    assign bout = bout_r;

`ifdef SERSUB_OVF_EN
    logic a_msb, b_msb, ovf_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == IDLE && start) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (last_bit) begin
            // d on the last shift is the result MSB.
            ovf_r <= (a_msb ^ b_msb) & (d ^ a_msb);
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule
